adc_scan_scheduler: RTL and testbench

//  Sequences the AdcReceiver serial-ADC front end through a periodic scan of enabled channels.

---
 rtl/adc_scan_scheduler.sv | 158 +++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
// Periodic scan sequencer for the AdcReceiver front end: walks the enabled channels on each
// scan tick, requests one conversion per channel and streams tagged results out.
module adc_scan_scheduler #(
  parameter int PERIOD_CYCLES  = 50000,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter bit UNIPOLAR       = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [7:0]  i_chan_mask,
  output logic [5:0]  o_tx_bits,
  output logic        o_request_conversion,
  input  logic        i_conv_in_process,
  input  logic        i_rx_dv,
  input  logic [11:0] i_rx_data,
  output logic        o_sample_valid,
  input  logic        i_sample_ready,
  output logic [2:0]  o_sample_chan,
  output logic [11:0] o_sample_data,
  output logic        o_busy,
  output logic        o_overrun,
  output logic        o_timeout
);

  localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] PERIOD_ONE   = PW'(1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_ONE  = TW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_REQ  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // Bit order expected by the ADC: S/D, O/S, S1, S0, UNI, SLP.
  function automatic logic [5:0] cfg_word(input logic [2:0] chan);
    return {1'b1, chan[0], chan[2], chan[1], UNIPOLAR, 1'b0};
  endfunction

  state_t          r_state;
  logic [PW-1:0]   r_period_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic [7:0]      r_mask;
  logic [3:0]      r_ptr;
  logic [5:0]      r_tx_bits;
  logic            r_req;
  logic            r_sample_valid;
  logic [2:0]      r_sample_chan;
  logic [11:0]     r_sample_data;
  logic            r_busy;
  logic            r_overrun;
  logic            r_timeout;

  logic            w_tick;
  logic            w_chan_on;
  logic            w_to_hit;

  assign w_tick    = i_enable && (r_period_cnt == PERIOD_LAST);
  assign w_chan_on = r_mask[r_ptr[2:0]];
  assign w_to_hit  = (r_to_cnt == TIMEOUT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period_cnt <= '0;
    end else if (!i_enable || w_tick) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + PERIOD_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_to_cnt       <= '0;
      r_mask         <= 8'h00;
      r_ptr          <= 4'd0;
      r_tx_bits      <= 6'd0;
      r_req          <= 1'b0;
      r_sample_valid <= 1'b0;
      r_sample_chan  <= 3'd0;
      r_sample_data  <= 12'h000;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_overrun <= w_tick && (r_state != ST_IDLE);
      r_timeout <= 1'b0;
      r_req     <= 1'b0;
      if (r_sample_valid && i_sample_ready) begin
        r_sample_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_tick && (i_chan_mask != 8'h00)) begin
            r_state <= ST_SEL;
            r_mask  <= i_chan_mask;
            r_ptr   <= 4'd0;
            r_busy  <= 1'b1;
          end
        end
        ST_SEL: begin
          if (!i_enable || r_ptr[3]) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (!w_chan_on) begin
            r_ptr <= r_ptr + 4'd1;
          end else if (!r_sample_valid && !i_conv_in_process) begin
            // Holding back while a sample is pending guarantees the single-entry output never overflows.
            r_state   <= ST_REQ;
            r_req     <= 1'b1;
            r_tx_bits <= cfg_word(r_ptr[2:0]);
            r_to_cnt  <= '0;
          end
        end
        ST_REQ: begin
          r_state  <= ST_WAIT;
          r_to_cnt <= r_to_cnt + TIMEOUT_ONE;
        end
        ST_WAIT: begin
          if (i_rx_dv || w_to_hit) begin
            if (i_rx_dv) begin
              r_sample_valid <= 1'b1;
              r_sample_chan  <= r_ptr[2:0];
              r_sample_data  <= i_rx_data;
            end else begin
              r_timeout <= 1'b1;
            end
            r_ptr   <= r_ptr + 4'd1;
            r_state <= i_enable ? ST_SEL : ST_IDLE;
            r_busy  <= i_enable;
          end else begin
            r_to_cnt <= r_to_cnt + TIMEOUT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_bits            = r_tx_bits;
  assign o_request_conversion = r_req;
  assign o_sample_valid       = r_sample_valid;
  assign o_sample_chan        = r_sample_chan;
  assign o_sample_data        = r_sample_data;
  assign o_busy               = r_busy;
  assign o_overrun            = r_overrun;
  assign o_timeout            = r_timeout;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: directed scenarios plus a randomized run, checked every cycle
// against a scan-level reference model and a set of hand-derived literal expectations.
module tb_adc_scan_scheduler;

  localparam int P = 20;
  localparam int T = 12;
  localparam bit U = 1'b1;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [7:0]  i_chan_mask = 8'h00;
  logic [5:0]  o_tx_bits;
  logic        o_request_conversion;
  logic        i_conv_in_process = 1'b0;
  logic        i_rx_dv = 1'b0;
  logic [11:0] i_rx_data = 12'h000;
  logic        o_sample_valid;
  logic        i_sample_ready = 1'b0;
  logic [2:0]  o_sample_chan;
  logic [11:0] o_sample_data;
  logic        o_busy;
  logic        o_overrun;
  logic        o_timeout;

  always #5 i_clk = ~i_clk;

  adc_scan_scheduler #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .UNIPOLAR(U)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_chan_mask(i_chan_mask),
    .o_tx_bits(o_tx_bits), .o_request_conversion(o_request_conversion),
    .i_conv_in_process(i_conv_in_process), .i_rx_dv(i_rx_dv), .i_rx_data(i_rx_data),
    .o_sample_valid(o_sample_valid), .i_sample_ready(i_sample_ready),
    .o_sample_chan(o_sample_chan), .o_sample_data(o_sample_data), .o_busy(o_busy),
    .o_overrun(o_overrun), .o_timeout(o_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: scan progress as "current channel" plus "age of the outstanding request".
  int          m_cnt, m_ch, m_age;
  bit          m_scan;
  logic [7:0]  m_mask;
  logic [5:0]  e_tx;
  logic        e_req, e_valid, e_busy, e_over, e_to;
  logic [2:0]  e_chan;
  logic [11:0] e_data;

  // ADC stand-in and observation logs
  int          adc_cnt = -1;
  logic [11:0] adc_pending = 12'h000;
  int          lat_cfg = 2;
  bit          adc_never = 1'b0;
  bit          lat_random = 1'b0;
  bit          noise = 1'b0;
  logic [11:0] chan_data [8];
  logic [5:0]  req_tx_q [$];
  int          req_cyc_q [$];
  logic [14:0] acc_q [$];
  int          acc_cyc_q [$];
  int          to_cyc_q [$];
  int          over_cyc_q [$];
  int          busy_cyc = -1;

  function automatic logic [5:0] cfg(input int c);
    return 6'(32 + (c % 2) * 16 + ((c / 4) % 2) * 8 + ((c / 2) % 2) * 4 + (U ? 2 : 0));
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ch = 0; m_age = -1; m_scan = 1'b0; m_mask = 8'h00;
    e_tx = 6'd0; e_req = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_over = 1'b0; e_to = 1'b0;
    e_chan = 3'd0; e_data = 12'h000;
  endtask

  task automatic model_update();
    bit tick, valid_pre, done;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    tick = i_enable && (m_cnt == P - 1);
    valid_pre = e_valid;
    done = 1'b0;
    m_cnt = (!i_enable || tick) ? 0 : m_cnt + 1;
    e_over = tick && m_scan;
    e_to = 1'b0;
    e_req = 1'b0;
    if (e_valid && i_sample_ready) e_valid = 1'b0;
    if (!m_scan) begin
      if (tick && i_chan_mask != 8'h00) begin
        m_scan = 1'b1; m_mask = i_chan_mask; m_ch = 0;
      end
    end else if (m_age < 0) begin
      if (!i_enable || m_ch > 7) m_scan = 1'b0;
      else if (!m_mask[m_ch]) m_ch++;
      else if (!valid_pre && !i_conv_in_process) begin
        e_req = 1'b1; m_age = 0; e_tx = cfg(m_ch);
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else begin
      if (i_rx_dv) begin
        e_valid = 1'b1; e_chan = 3'(m_ch); e_data = i_rx_data; done = 1'b1;
      end else if (m_age == T - 1) begin
        e_to = 1'b1; done = 1'b1;
      end else begin
        m_age++;
      end
      if (done) begin
        m_ch++; m_age = -1;
        if (!i_enable) m_scan = 1'b0;
      end
    end
    e_busy = m_scan;
  endtask

  task automatic compare();
    n_tests++;
    if ({o_tx_bits, o_request_conversion, o_sample_valid, o_sample_chan, o_sample_data,
         o_busy, o_overrun, o_timeout} !==
        {e_tx, e_req, e_valid, e_chan, e_data, e_busy, e_over, e_to}) begin
      n_fail++;
      $display("FAIL cycle_model @%0d: got tx=%b req=%b v=%b ch=%0d d=%h busy=%b ovr=%b to=%b; expected tx=%b req=%b v=%b ch=%0d d=%h busy=%b ovr=%b to=%b",
               cyc, o_tx_bits, o_request_conversion, o_sample_valid, o_sample_chan, o_sample_data,
               o_busy, o_overrun, o_timeout, e_tx, e_req, e_valid, e_chan, e_data, e_busy, e_over, e_to);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic adc_drive();
    i_rx_dv = 1'b0;
    if (adc_cnt == 0) begin
      i_rx_dv = 1'b1; i_rx_data = adc_pending; adc_cnt = -1;
    end else if (adc_cnt > 0) begin
      adc_cnt--;
    end
    if (o_request_conversion) begin
      adc_pending = chan_data[{o_tx_bits[3], o_tx_bits[2], o_tx_bits[4]}];
      if (lat_random) adc_cnt = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, T));
      else adc_cnt = adc_never ? -1 : lat_cfg;
    end
    if (noise && adc_cnt < 0 && $urandom_range(0, 99) < 3) begin
      i_rx_dv = 1'b1; i_rx_data = 12'($urandom);
    end
    i_conv_in_process = (adc_cnt >= 0) || (noise && $urandom_range(0, 99) < 5);
  endtask

  task automatic step();
    if (o_sample_valid && i_sample_ready) begin
      acc_q.push_back({o_sample_chan, o_sample_data});
      acc_cyc_q.push_back(cyc);
    end
    @(posedge i_clk);
    model_update();
    @(negedge i_clk);
    cyc++;
    compare();
    if (o_request_conversion) begin
      req_tx_q.push_back(o_tx_bits);
      req_cyc_q.push_back(cyc);
    end
    if (o_timeout) to_cyc_q.push_back(cyc);
    if (o_overrun) over_cyc_q.push_back(cyc);
    if (o_busy && busy_cyc < 0) busy_cyc = cyc;
    adc_drive();
  endtask

  task automatic clear_logs();
    req_tx_q.delete(); req_cyc_q.delete(); acc_q.delete(); acc_cyc_q.delete();
    to_cyc_q.delete(); over_cyc_q.delete(); busy_cyc = -1;
  endtask

  task automatic idle_out();
    int k;
    i_enable = 1'b0;
    i_sample_ready = 1'b1;
    k = 0;
    while ((o_busy || o_sample_valid) && k < 400) begin
      step();
      k++;
    end
    check("drain_idle", {31'd0, o_busy | o_sample_valid}, 32'd0);
    step();
    step();
  endtask

  task automatic wait_scan(input string name, input int budget);
    int k;
    k = 0;
    while (!o_busy && k < budget) begin
      step();
      k++;
    end
    check({name, "_start"}, {31'd0, o_busy}, 32'd1);
    k = 0;
    while (o_busy && k < budget) begin
      step();
      k++;
    end
    check({name, "_end"}, {31'd0, o_busy}, 32'd0);
    i_enable = 1'b0;
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    adc_cnt = -1;
    #1;
    check("async_reset_outputs",
          {6'd0, o_tx_bits, o_request_conversion, o_sample_valid, o_sample_chan, o_sample_data,
           o_busy, o_overrun, o_timeout}, 32'd0);
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  initial begin
    int k;
    model_reset();
    for (int i = 0; i < 8; i++) chan_data[i] = 12'(i * 12'h111);
    step();
    step();
    check("reset_state", {o_busy, o_sample_valid, o_request_conversion, o_tx_bits}, 32'd0);
    i_rst_n = 1'b1;
    step();

    // Two-channel scan, fast ADC, consumer always ready
    clear_logs();
    chan_data[0] = 12'hABC; chan_data[2] = 12'h123;
    lat_cfg = 3; i_chan_mask = 8'h05; i_sample_ready = 1'b1; i_enable = 1'b1;
    wait_scan("t1", 200);
    idle_out();
    check("t1_nsamples", acc_q.size(), 32'd2);
    check("t1_nreq", req_tx_q.size(), 32'd2);
    if (acc_q.size() == 2 && req_tx_q.size() == 2) begin
      check("t1_sample0", 32'(acc_q[0]), 32'h0ABC);
      check("t1_sample1", 32'(acc_q[1]), 32'h2123);
      check("t1_tx0", 32'(req_tx_q[0]), 32'b100010);
      check("t1_tx1", 32'(req_tx_q[1]), 32'b100110);
    end

    // Silent ADC on channel 7: exactly one timeout, T cycles after the request
    clear_logs();
    adc_never = 1'b1; i_chan_mask = 8'h80; i_enable = 1'b1;
    wait_scan("t2", 300);
    idle_out();
    adc_never = 1'b0;
    check("t2_ntimeout", to_cyc_q.size(), 32'd1);
    check("t2_nsamples", acc_q.size(), 32'd0);
    if (to_cyc_q.size() == 1 && req_cyc_q.size() == 1)
      check("t2_timeout_delay", 32'(to_cyc_q[0] - req_cyc_q[0]), 32'(T));

    // Backpressure: second request withheld while the first sample is unaccepted
    clear_logs();
    chan_data[0] = 12'h5A5; chan_data[1] = 12'h3C3;
    lat_cfg = 2; i_sample_ready = 1'b0; i_chan_mask = 8'h03; i_enable = 1'b1;
    k = 0;
    while (!o_sample_valid && k < 100) begin
      step();
      k++;
    end
    for (int i = 0; i < 25; i++) step();
    check("t3_stalled_valid", {31'd0, o_sample_valid}, 32'd1);
    check("t3_stalled_data", {17'd0, o_sample_chan, o_sample_data}, 32'h05A5);
    check("t3_req_withheld", req_cyc_q.size(), 32'd1);
    i_sample_ready = 1'b1;
    k = 0;
    while (o_busy && k < 200) begin
      step();
      k++;
    end
    idle_out();
    check("t3_nsamples", acc_q.size(), 32'd2);
    if (acc_q.size() == 2) check("t3_sample1", 32'(acc_q[1]), 32'h13C3);

    // Slow ADC, full mask: scan outlives the period, overrun at the second tick
    clear_logs();
    for (int i = 0; i < 8; i++) chan_data[i] = 12'(12'h101 * (i + 1));
    lat_cfg = 8; i_chan_mask = 8'hFF; i_enable = 1'b1;
    wait_scan("t4", 400);
    idle_out();
    check("t4_nsamples", acc_q.size(), 32'd8);
    if (acc_q.size() == 8)
      for (int i = 0; i < 8; i++) check("t4_chan_order", 32'(acc_q[i][14:12]), 32'(i));
    check("t4_overrun_seen", {31'd0, over_cyc_q.size() > 0}, 32'd1);
    if (over_cyc_q.size() > 0) check("t4_overrun_cycle", 32'(over_cyc_q[0]), 32'(busy_cyc + P));

    // Data-valid lands on the very cycle the timeout would expire
    clear_logs();
    chan_data[0] = 12'hE07; lat_cfg = T - 2; i_chan_mask = 8'h01; i_enable = 1'b1;
    wait_scan("t5", 200);
    idle_out();
    check("t5_ntimeout", to_cyc_q.size(), 32'd0);
    check("t5_nsamples", acc_q.size(), 32'd1);
    if (acc_q.size() == 1 && req_cyc_q.size() == 1) begin
      check("t5_sample", 32'(acc_q[0]), 32'h0E07);
      check("t5_latency", 32'(acc_cyc_q[0] - req_cyc_q[0]), 32'(T));
    end

    // Reset mid-WAIT, then mid-request-pulse
    clear_logs();
    lat_cfg = 6; i_chan_mask = 8'h05; i_enable = 1'b1;
    k = 0;
    while (req_cyc_q.size() == 0 && k < 60) begin
      step();
      k++;
    end
    step();
    step();
    pulse_reset();
    clear_logs();
    k = 0;
    while (req_cyc_q.size() == 0 && k < 60) begin
      step();
      k++;
    end
    check("t6_restart_req", req_cyc_q.size(), 32'd1);
    if (req_tx_q.size() == 1) check("t6_restart_ch0", 32'(req_tx_q[0]), 32'b100010);
    check("t6_mid_pulse_high", {31'd0, o_request_conversion}, 32'd1);
    pulse_reset();
    idle_out();

    // Randomized run: enable, mask, ready, ADC latency, spurious dv/busy all varied
    clear_logs();
    lat_random = 1'b1; noise = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      i_enable = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 6) == 0) i_chan_mask = 8'($urandom);
      i_sample_ready = ($urandom_range(0, 99) < 70);
      chan_data[$urandom_range(0, 7)] = 12'($urandom);
      step();
    end
    lat_random = 1'b0; noise = 1'b0;
    idle_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
